// File: rtl/commit_trace.sv
// commit_trace: captures execute-stage commit events (reg write, CSR write,
// store) into a show-ahead FIFO and streams them out over valid/ready.
// A store to the host mailbox latches its data, drains the FIFO, then halts.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   evt_valid/kind/pc/addr/data/strb   commit event from execute stage
//   out_valid/ready/kind/pc/addr/data/strb   trace stream (head of FIFO)
//   overflow, drop_count  sticky drop flag, saturating drop counter
//   done, done_code       host mailbox write seen and its data
//   halted                done and FIFO drained; terminal until reset
module commit_trace #(
   parameter int unsigned DEPTH     = 16,
   parameter logic [31:0] HOST_ADDR = 32'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        evt_valid,
   input  logic [1:0]  evt_kind,
   input  logic [31:0] evt_pc,
   input  logic [31:0] evt_addr,
   input  logic [31:0] evt_data,
   input  logic [3:0]  evt_strb,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  out_kind,
   output logic [31:0] out_pc,
   output logic [31:0] out_addr,
   output logic [31:0] out_data,
   output logic [3:0]  out_strb,
   output logic        overflow,
   output logic [15:0] drop_count,
   output logic        done,
   output logic [31:0] done_code,
   output logic        halted
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } rec_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t           state;
   rec_t             mem [DEPTH];
   rec_t             head;
   rec_t             head_nxt;
   rec_t             evt_rec;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_nxt;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic             qual;
   logic             host_hit;
   logic             pop;
   logic             push;
   logic             drop;

   // Push/pop/drop decisions and the next head record
   always_comb begin
      evt_rec   = '{kind: evt_kind, pc: evt_pc, addr: evt_addr,
                    data: evt_data, strb: evt_strb};
      qual      = evt_valid && (evt_kind != 2'd3) &&
                  ((evt_kind != 2'd2) || (evt_strb != 4'd0));
      host_hit  = (state == RUN) && qual && (evt_kind == 2'd2) &&
                  (evt_addr[31:2] == HOST_ADDR[31:2]);
      pop       = out_valid && out_ready;
      push      = (state == RUN) && qual &&
                  ((count != CNT_W'(DEPTH)) || pop);
      drop      = (state == RUN) && qual && !push;
      count_nxt = count + CNT_W'(push) - CNT_W'(pop);
      rd_nxt    = rd_ptr + PTR_W'(pop);
      head_nxt  = '0;
      // An entry written into a FIFO that is empty after this pop becomes
      // the head directly; storage is not yet written.
      if (count_nxt != '0) begin
         if (push && (count == CNT_W'(pop))) begin
            head_nxt = evt_rec;
         end else begin
            head_nxt = mem[rd_nxt];
         end
      end
   end

   // Entry storage (no reset needed; pointers define validity)
   always_ff @(posedge clock) begin
      if (!reset && push) begin
         mem[wr_ptr] <= evt_rec;
      end
   end

   // Control state, pointers, status and registered head
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= RUN;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         out_valid  <= 1'b0;
         head       <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
         done       <= 1'b0;
         done_code  <= '0;
         halted     <= 1'b0;
      end else begin
         rd_ptr    <= rd_nxt;
         count     <= count_nxt;
         out_valid <= (count_nxt != '0);
         head      <= head_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
               drop_count <= drop_count + 16'd1;
            end
         end
         case (state)
            RUN: begin
               if (host_hit) begin
                  done      <= 1'b1;
                  done_code <= evt_data;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if ((count == '0) || ((count == CNT_W'(1)) && pop)) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

   assign out_kind = head.kind;
   assign out_pc   = head.pc;
   assign out_addr = head.addr;
   assign out_data = head.data;
   assign out_strb = head.strb;

endmodule

// File: tb/tb_commit_trace.sv
// tb_commit_trace: directed, self-checking bench for commit_trace
// (DEPTH=16, host mailbox at 0x80001000).
module tb_commit_trace;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        evt_valid = 1'b0;
   logic [1:0]  evt_kind = '0;
   logic [31:0] evt_pc = '0;
   logic [31:0] evt_addr = '0;
   logic [31:0] evt_data = '0;
   logic [3:0]  evt_strb = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [1:0]  out_kind;
   logic [31:0] out_pc;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   logic [3:0]  out_strb;
   logic        overflow;
   logic [15:0] drop_count;
   logic        done;
   logic [31:0] done_code;
   logic        halted;

   int total = 0;
   int bad   = 0;

   logic [101:0] head_obs;
   assign head_obs = {out_kind, out_pc, out_addr, out_data, out_strb};

   commit_trace #(.DEPTH(16), .HOST_ADDR(32'h8000_1000)) dut (
      .clock(clock), .reset(reset),
      .evt_valid(evt_valid), .evt_kind(evt_kind), .evt_pc(evt_pc),
      .evt_addr(evt_addr), .evt_data(evt_data), .evt_strb(evt_strb),
      .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
      .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
      .out_strb(out_strb), .overflow(overflow), .drop_count(drop_count),
      .done(done), .done_code(done_code), .halted(halted)
   );

   always #5 clock = ~clock;

   function automatic logic [101:0] mk(input logic [1:0] k, input logic [31:0] pc,
                                       input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] s);
      return {k, pc, a, d, s};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [1:0] k, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      evt_valid = 1'b1; evt_kind = k; evt_pc = pc; evt_addr = a; evt_data = d; evt_strb = s;
   endtask

   task automatic idle();
      evt_valid = 1'b0; evt_kind = '0; evt_pc = '0; evt_addr = '0; evt_data = '0; evt_strb = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      out_ready = 1'b0;
      do_reset();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      total++; if (head_obs !== '0) begin bad++; $display("FAIL reset_head got=%h want=0", head_obs); end
      total++; if ({overflow, drop_count, done, done_code, halted} !== '0) begin bad++;
         $display("FAIL reset_status ovf=%b drops=%0d done=%b code=%h halt=%b want all 0",
                  overflow, drop_count, done, done_code, halted); end
   endtask

   task automatic test_ignored();
      out_ready = 1'b1;
      drive(2'd2, 32'h50, 32'h8000_1000, 32'h11, 4'b0000);  // store with no strobes, even to host
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ign_strb0 got=%b want=0", out_valid); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL ign_strb0_done got=%b want=0", done); end
      drive(2'd3, 32'h54, 32'h3, 32'h22, 4'hF);
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ign_kind3 got=%b want=0", out_valid); end
      drive(2'd0, 32'h58, 32'h4, 32'h33, 4'h0);
      evt_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ign_novalid got=%b want=0", out_valid); end
      total++; if ({overflow, drop_count} !== '0) begin bad++;
         $display("FAIL ign_drops ovf=%b drops=%0d want 0", overflow, drop_count); end
      idle();
   endtask

   task automatic test_in_order();
      logic [31:0] pcs [3] = '{32'h100, 32'h104, 32'h108};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(2'd0, pcs[i], 32'(i + 5), 32'(i + 1), 4'h0);
         tick();
         total++; if (out_valid !== 1'b1 || head_obs !== mk(2'd0, pcs[i], 32'(i + 5), 32'(i + 1), 4'h0)) begin
            bad++; $display("FAIL order_rec%0d got v=%b %h want v=1 pc=%h", i, out_valid, head_obs, pcs[i]); end
      end
      idle();
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL order_empty got=%b want=0", out_valid); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL order_ovf got=%b want=0", overflow); end
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(2'd1, 32'h200 + 32'(4 * i), 32'(i), 32'h1000 + 32'(i), 4'h0);
         tick();
      end
      idle();
      total++; if (drop_count !== 16'd4) begin bad++; $display("FAIL ovf_drops got=%0d want=4", drop_count); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         total++; if (out_valid !== 1'b1 || head_obs !== mk(2'd1, 32'h200 + 32'(4 * i), 32'(i), 32'h1000 + 32'(i), 4'h0)) begin
            bad++; $display("FAIL ovf_rec%0d got v=%b %h want pc=%h", i, out_valid, head_obs, 32'h200 + 32'(4 * i)); end
         tick();
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b want=0", out_valid); end
   endtask

   task automatic test_full_push_pop();
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive(2'd0, 32'h400 + 32'(4 * i), 32'(i), 32'h2000 + 32'(i), 4'h0);
         tick();
      end
      // Non-qualifying events at full never count as drops
      drive(2'd3, 32'h4F0, 32'h1, 32'h1, 4'hF);
      tick();
      drive(2'd2, 32'h4F4, 32'h40, 32'h1, 4'h0);
      tick();
      total++; if (drop_count !== 16'd4) begin bad++; $display("FAIL full_ignored drops got=%0d want=4", drop_count); end
      out_ready = 1'b1;
      drive(2'd2, 32'h500, 32'h40, 32'hABCD, 4'b0011);
      tick();
      idle();
      total++; if (drop_count !== 16'd4) begin bad++; $display("FAIL full_pp drops got=%0d want=4", drop_count); end
      for (int i = 1; i < 16; i++) begin
         total++; if (out_valid !== 1'b1 || head_obs !== mk(2'd0, 32'h400 + 32'(4 * i), 32'(i), 32'h2000 + 32'(i), 4'h0)) begin
            bad++; $display("FAIL full_rec%0d got v=%b %h want pc=%h", i, out_valid, head_obs, 32'h400 + 32'(4 * i)); end
         tick();
      end
      total++; if (out_valid !== 1'b1 || head_obs !== mk(2'd2, 32'h500, 32'h40, 32'hABCD, 4'b0011)) begin
         bad++; $display("FAIL full_newrec got v=%b %h want pc=500", out_valid, head_obs); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%b want=0", out_valid); end
   endtask

   task automatic test_host();
      out_ready = 1'b0;
      drive(2'd0, 32'h700, 32'd1, 32'hA, 4'h0); tick();
      drive(2'd1, 32'h704, 32'h300, 32'hB, 4'h0); tick();
      drive(2'd2, 32'h708, 32'h8000_1002, 32'h2A, 4'b0100); tick();
      total++; if (done !== 1'b1 || done_code !== 32'h2A) begin bad++;
         $display("FAIL host_done got done=%b code=%h want 1/2a", done, done_code); end
      drive(2'd0, 32'h70C, 32'd2, 32'hC, 4'h0); tick();
      idle();
      total++; if (drop_count !== 16'd4) begin bad++; $display("FAIL host_ignore drops got=%0d want=4", drop_count); end
      out_ready = 1'b1;
      total++; if (out_valid !== 1'b1 || head_obs !== mk(2'd0, 32'h700, 32'd1, 32'hA, 4'h0)) begin
         bad++; $display("FAIL host_recA got v=%b %h", out_valid, head_obs); end
      tick();
      total++; if (out_valid !== 1'b1 || head_obs !== mk(2'd1, 32'h704, 32'h300, 32'hB, 4'h0)) begin
         bad++; $display("FAIL host_recB got v=%b %h", out_valid, head_obs); end
      tick();
      total++; if (out_valid !== 1'b1 || head_obs !== mk(2'd2, 32'h708, 32'h8000_1002, 32'h2A, 4'b0100)) begin
         bad++; $display("FAIL host_recS got v=%b %h", out_valid, head_obs); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL host_early_halt got=%b want=0", halted); end
      tick();
      total++; if (halted !== 1'b1 || out_valid !== 1'b0 || done !== 1'b1) begin bad++;
         $display("FAIL host_halt got halt=%b valid=%b done=%b want 1/0/1", halted, out_valid, done); end
      drive(2'd0, 32'h710, 32'd3, 32'hD, 4'h0); tick();
      idle();
      total++; if (out_valid !== 1'b0 || halted !== 1'b1) begin bad++;
         $display("FAIL host_post got valid=%b halt=%b want 0/1", out_valid, halted); end
   endtask

   task automatic test_reset_drain();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(2'd0, 32'h800 + 32'(4 * i), 32'(i), 32'(i), 4'h0); tick();
      end
      drive(2'd2, 32'h810, 32'h8000_1000, 32'h55, 4'hF); tick();
      idle();
      total++; if (done !== 1'b1 || out_valid !== 1'b1) begin bad++;
         $display("FAIL rd_setup got done=%b valid=%b want 1/1", done, out_valid); end
      do_reset();
      total++; if (out_valid !== 1'b0 || done !== 1'b0 || halted !== 1'b0 || done_code !== '0) begin bad++;
         $display("FAIL rd_cleared got valid=%b done=%b halt=%b code=%h want 0", out_valid, done, halted, done_code); end
      drive(2'd0, 32'h900, 32'd9, 32'h99, 4'h0); tick();
      idle();
      total++; if (out_valid !== 1'b1 || head_obs !== mk(2'd0, 32'h900, 32'd9, 32'h99, 4'h0)) begin
         bad++; $display("FAIL rd_accept got v=%b %h want pc=900", out_valid, head_obs); end
   endtask

   initial begin
      test_reset();
      test_ignored();
      test_in_order();
      test_overflow();
      test_full_push_pop();
      test_host();
      test_reset_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/commit_trace.md
Name: commit_trace

Overview:
- Captures execute-stage commit events (register write, CSR write, store) into a FIFO and streams them to a consumer over valid/ready.
- Sits directly downstream of the execute stage; its inputs are the execute stage's commit fields.
- Detects the store to the host mailbox address, latches the written value, drains the FIFO, then halts.
- Replaces hierarchical peeking by benches and debug logic with a single synthesizable trace port.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- HOST_ADDR, 32'h0, host mailbox byte address; only bits [31:2] are compared.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- evt_valid  input  1  commit event present this cycle
- evt_kind  input  2  0=reg write, 1=CSR write, 2=store, 3=reserved (ignored)
- evt_pc  input  32  PC of the committing instruction
- evt_addr  input  32  reg index (zero-extended), CSR address (zero-extended), or store byte address
- evt_data  input  32  write data or store data
- evt_strb  input  4  store byte enables; don't-care for other kinds
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_kind  output  2  head kind
- out_pc  output  32  head PC
- out_addr  output  32  head address
- out_data  output  32  head data
- out_strb  output  4  head strobes
- overflow  output  1  sticky: at least one event was dropped
- drop_count  output  16  saturating count of dropped events
- done  output  1  host mailbox write seen (sticky)
- done_code  output  32  data of the host mailbox write
- halted  output  1  done set and FIFO fully drained (sticky)

Behaviour:
- Reset (clock edge with reset=1): FIFO empty. Outputs: out_valid=0, out_kind/out_pc/out_addr/out_data/out_strb=0, overflow=0, drop_count=0, done=0, done_code=0, halted=0. State=RUN. Reset mid-stream discards all entries; nothing in flight survives.
- Qualifying event: evt_valid=1, evt_kind!=3, and, for kind 2, evt_strb!=0. All other events are ignored and are never counted as drops.
- FIFO:
  - Show-ahead: head fields are driven from storage whenever out_valid=1.
  - Pop occurs when out_valid & out_ready.
  - Write latency 1: an event accepted at edge N into an empty FIFO gives out_valid=1 after edge N.
- Push:
  - In RUN, a qualifying event is pushed if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle (simultaneous push/pop at full is accepted).
  - Otherwise the event is dropped: overflow<=1, drop_count increments and saturates at 16'hFFFF.
- Simultaneous push and pop at empty: the pop is impossible (out_valid=0); the push proceeds normally.
- Pointers: log2(DEPTH) bits, wrapping naturally. Occupancy counter is log2(DEPTH)+1 bits.
- Host detection (RUN only): a qualifying kind-2 event with evt_addr[31:2]==HOST_ADDR[31:2].
  - The event itself is pushed, or dropped under the same full rule.
  - done<=1, done_code<=evt_data, state<=DRAIN.
- State machine:
  - RUN: as above.
  - DRAIN: all evt_* ignored (no push, no drop count); pops continue. When count==0, or when count==1 with a pop this cycle, state<=HALT and halted<=1 at that edge.
  - HALT: terminal until reset. Events are ignored and out_valid=0.
- done, overflow, halted and done_code hold their values until reset.

Test Plan:
- Reset, then 3 reg writes (pc 0x100/0x104/0x108, addr 5/6/7, data 1/2/3) with out_ready=1 -> the three records appear in order, each one cycle after input; overflow=0.
- DEPTH=16, out_ready=0, 20 qualifying events -> first 16 held, drop_count=4, overflow=1; release out_ready -> exactly 16 records in input order.
- Full FIFO, out_ready=1, and a new event in the same cycle -> event accepted, count stays 16, drop_count unchanged.
- Store kind 2 with strb=0 and kind 3 events -> nothing pushed, drop_count=0.
- HOST_ADDR=0x80001000, 2 entries queued, store to 0x80001002 with strb=4'b0100, data=0x2A -> done=1 and done_code=0x2A the next cycle; later events ignored; after 3 pops halted=1 and out_valid=0.
- Reset asserted in DRAIN with 5 entries queued -> next cycle out_valid=0, done=0, halted=0; new events accepted again.
